// File: rtl/upsampling_unit.sv
// Nearest-neighbour upsampler: buffers one input row, then replays it SCALE times
// with every pixel repeated SCALE times. Valid/ready on both sides, last marks frame end.
module upsampling_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int SCALE      = 2,
  parameter int IN_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] input_data,
  input  logic                  input_valid,
  output logic                  input_ready,
  input  logic                  last_input,
  output logic [DATA_WIDTH-1:0] output_data,
  output logic                  output_valid,
  input  logic                  output_ready,
  output logic                  last_output
);
  localparam int CW = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;
  localparam int LW = (IN_WIDTH > 0) ? $clog2(IN_WIDTH + 1) : 1;
  localparam int RW = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam logic [CW-1:0] COL_MAX = CW'(IN_WIDTH - 1);
  localparam logic [RW-1:0] REP_MAX = RW'(SCALE - 1);

  typedef enum logic {S_LOAD, S_EMIT} state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [DATA_WIDTH-1:0] r_buf [IN_WIDTH];
  logic [CW-1:0]         r_in_col;
  logic [CW-1:0]         r_src_col;
  logic [LW-1:0]         r_row_len;
  logic [RW-1:0]         r_rep_x;
  logic [RW-1:0]         r_rep_y;
  logic                  r_frame_last;
  logic [DATA_WIDTH-1:0] r_out_data;

  logic [DATA_WIDTH-1:0] w_out_data_next;
  logic [CW-1:0]         w_src_col_next;
  logic [CW-1:0]         w_last_col;
  logic                  w_in_xfer;
  logic                  w_out_xfer;
  logic                  w_row_done;
  logic                  w_end_x;
  logic                  w_end_col;
  logic                  w_end_row;

  assign w_in_xfer  = input_valid && input_ready;
  assign w_out_xfer = output_valid && output_ready;
  assign w_row_done = w_in_xfer && ((r_in_col == COL_MAX) || last_input);
  assign w_last_col = CW'(r_row_len - LW'(1));
  assign w_end_x    = (r_rep_x == REP_MAX);
  assign w_end_col  = w_end_x && (r_src_col == w_last_col);
  assign w_end_row  = w_end_col && (r_rep_y == REP_MAX);

  always_comb begin
    w_src_col_next = r_src_col;
    if (w_end_col)
      w_src_col_next = '0;
    else if (w_end_x)
      w_src_col_next = r_src_col + CW'(1);
  end

  // Prefetch the pixel shown next; a one-pixel row bypasses the buffer write in flight.
  always_comb begin
    w_out_data_next = r_buf[w_src_col_next];
    if (r_state == S_LOAD)
      w_out_data_next = (r_in_col == '0) ? input_data : r_buf[0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_state <= S_LOAD;
    else
      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_LOAD: if (w_row_done) w_state_next = S_EMIT;
      S_EMIT: if (w_out_xfer && w_end_row) w_state_next = S_LOAD;
      default: w_state_next = S_LOAD;
    endcase
  end

  always_comb begin
    input_ready  = (r_state == S_LOAD) && !reset;
    output_valid = (r_state == S_EMIT);
    last_output  = (r_state == S_EMIT) && r_frame_last && w_end_row;
    output_data  = r_out_data;
  end

  // Row storage is never reset; stale entries past row_len are unreachable.
  always_ff @(posedge clk) begin
    if (w_in_xfer)
      r_buf[r_in_col] <= input_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_in_col     <= '0;
      r_src_col    <= '0;
      r_row_len    <= '0;
      r_rep_x      <= '0;
      r_rep_y      <= '0;
      r_frame_last <= 1'b0;
      r_out_data   <= '0;
    end else begin
      if (w_in_xfer) begin
        if (w_row_done) begin
          r_row_len    <= LW'(r_in_col) + LW'(1);
          r_frame_last <= last_input;
          r_in_col     <= '0;
          r_src_col    <= '0;
          r_rep_x      <= '0;
          r_rep_y      <= '0;
          r_out_data   <= w_out_data_next;
        end else begin
          r_in_col <= r_in_col + CW'(1);
        end
      end
      if (w_out_xfer) begin
        r_src_col  <= w_src_col_next;
        r_out_data <= w_out_data_next;
        r_rep_x    <= w_end_x ? '0 : r_rep_x + RW'(1);
        if (w_end_col)
          r_rep_y <= w_end_row ? '0 : r_rep_y + RW'(1);
        if (w_end_row)
          r_frame_last <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_upsampling_unit.sv
// Bench for upsampling_unit: a row-expansion model checked every cycle on a SCALE=2
// instance, literal sequence checks, and a SCALE=1 instance checked by hand.
module tb_upsampling_unit;
  localparam int SA = 2;
  localparam int WA = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] a_in_data = '0;
  logic        a_in_valid = 1'b0, a_in_last = 1'b0, a_in_ready;
  logic [31:0] a_out_data;
  logic        a_out_valid, a_out_last;
  logic        a_out_ready = 1'b1;

  logic [31:0] b_in_data = '0;
  logic        b_in_valid = 1'b0, b_in_last = 1'b0, b_in_ready;
  logic [31:0] b_out_data;
  logic        b_out_valid, b_out_last;
  logic        b_out_ready = 1'b1;

  upsampling_unit #(.DATA_WIDTH(32), .SCALE(SA), .IN_WIDTH(WA)) dut_a (
    .clk(clk), .reset(rst),
    .input_data(a_in_data), .input_valid(a_in_valid), .input_ready(a_in_ready),
    .last_input(a_in_last),
    .output_data(a_out_data), .output_valid(a_out_valid), .output_ready(a_out_ready),
    .last_output(a_out_last)
  );

  upsampling_unit #(.DATA_WIDTH(32), .SCALE(1), .IN_WIDTH(3)) dut_b (
    .clk(clk), .reset(rst),
    .input_data(b_in_data), .input_valid(b_in_valid), .input_ready(b_in_ready),
    .last_input(b_in_last),
    .output_data(b_out_data), .output_valid(b_out_valid), .output_ready(b_out_ready),
    .last_output(b_out_last)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Reference model: expected beats of every completed input row
  typedef struct {
    logic [31:0] d;
    logic        l;
    logic        re;
  } beat_t;

  beat_t       exp_q[$];
  logic [31:0] row_q[$];
  logic [31:0] log_d[$];
  logic        log_l[$];
  int          exp_lit[$];
  beat_t       nb;
  logic        chk_latency = 1'b0, chk_ready = 1'b0, hold_prev = 1'b0;
  logic [31:0] prev_d;
  logic        prev_l, prev_v;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      row_q.delete();
      chk_latency = 1'b0;
      chk_ready   = 1'b0;
      hold_prev   = 1'b0;
    end else begin
      chk("no_overlap", {31'd0, a_in_ready && a_out_valid}, 32'd0);
      if (chk_latency) begin
        chk("latency_valid", {31'd0, a_out_valid}, 32'd1);
        chk_latency = 1'b0;
      end
      if (chk_ready) begin
        chk("ready_after_row", {31'd0, a_in_ready}, 32'd1);
        chk_ready = 1'b0;
      end
      if (hold_prev) begin
        chk("hold_data", a_out_data, prev_d);
        chk("hold_valid", {31'd0, a_out_valid}, {31'd0, prev_v});
        chk("hold_last", {31'd0, a_out_last}, {31'd0, prev_l});
      end
      if (a_out_valid) begin
        chk("beat_expected", {31'd0, exp_q.size() > 0}, 32'd1);
        if (exp_q.size() > 0) begin
          chk("out_data", a_out_data, exp_q[0].d);
          chk("out_last", {31'd0, a_out_last}, {31'd0, exp_q[0].l});
          if (a_out_ready) begin
            log_d.push_back(a_out_data);
            log_l.push_back(a_out_last);
            if (exp_q[0].re) chk_ready = 1'b1;
            void'(exp_q.pop_front());
          end
        end
      end
      hold_prev = a_out_valid && !a_out_ready;
      prev_d = a_out_data;
      prev_v = a_out_valid;
      prev_l = a_out_last;
      if (a_in_valid && a_in_ready) begin
        row_q.push_back(a_in_data);
        if (row_q.size() == WA || a_in_last) begin
          for (int y = 0; y < SA; y++)
            for (int c = 0; c < row_q.size(); c++)
              for (int x = 0; x < SA; x++) begin
                nb.d  = row_q[c];
                nb.re = (y == SA - 1) && (c == row_q.size() - 1) && (x == SA - 1);
                nb.l  = a_in_last && nb.re;
                exp_q.push_back(nb);
              end
          row_q.delete();
          chk_latency = 1'b1;
        end
      end
    end
  end

  logic bp_mode = 1'b0;
  int   bp_cnt  = 0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (bp_mode) begin
        a_out_ready = (bp_cnt % 3 == 0);
        bp_cnt++;
      end else begin
        a_out_ready = 1'b1;
      end
    end
  end

  task automatic send_a(input logic [31:0] d, input logic l);
    bit ok = 1'b0;
    a_in_data = d; a_in_valid = 1'b1; a_in_last = l;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      ok = a_in_ready && !rst;
      @(posedge clk);
      #1;
      if (ok) break;
    end
    a_in_valid = 1'b0; a_in_last = 1'b0;
    chk("send_accept", {31'd0, ok}, 32'd1);
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #3;
      if (exp_q.size() == 0 && row_q.size() == 0 && !a_out_valid && a_in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk("idle_reached", {31'd0, ok}, 32'd1);
  endtask

  task automatic chk_log(input string name, input int last_idx);
    chk({name, "_count"}, log_d.size(), exp_lit.size());
    for (int i = 0; i < exp_lit.size() && i < log_d.size(); i++) begin
      chk({name, "_data"}, log_d[i], exp_lit[i]);
      chk({name, "_last"}, {31'd0, log_l[i]}, {31'd0, i == last_idx});
    end
    log_d.delete();
    log_l.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got5;
    #1 rst = 1'b1;
    #3;
    chk("rst_out_valid", {31'd0, a_out_valid}, 32'd0);
    chk("rst_out_last", {31'd0, a_out_last}, 32'd0);
    chk("rst_out_data", a_out_data, 32'd0);
    chk("rst_in_ready", {31'd0, a_in_ready}, 32'd0);
    chk("rst_b_valid", {31'd0, b_out_valid}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    #1 chk("ready_after_rst", {31'd0, a_in_ready}, 32'd1);

    // Single full row, last on 4
    for (int i = 1; i <= 4; i++) send_a(i, i == 4);
    wait_idle();
    exp_lit = '{1,1,2,2,3,3,4,4,1,1,2,2,3,3,4,4};
    $display("scenario single_row beats=%0d", log_d.size());
    chk_log("s1", 15);

    // Two rows, last only on pixel 8
    for (int i = 1; i <= 8; i++) send_a(i, i == 8);
    wait_idle();
    exp_lit = '{1,1,2,2,3,3,4,4,1,1,2,2,3,3,4,4,
                5,5,6,6,7,7,8,8,5,5,6,6,7,7,8,8};
    $display("scenario two_rows beats=%0d", log_d.size());
    chk_log("s2", 31);

    // Short row 9,7 leaves 3,4 stale in the buffer
    send_a(9, 1'b0);
    send_a(7, 1'b1);
    wait_idle();
    exp_lit = '{9,9,7,7,9,9,7,7};
    $display("scenario short_row beats=%0d", log_d.size());
    chk_log("s3", 7);

    // Backpressure pattern 1,0,0
    bp_mode = 1'b1;
    for (int i = 1; i <= 4; i++) send_a(i, i == 4);
    wait_idle();
    bp_mode = 1'b0;
    exp_lit = '{1,1,2,2,3,3,4,4,1,1,2,2,3,3,4,4};
    $display("scenario backpressure beats=%0d", log_d.size());
    chk_log("s4", 15);

    // Reset after 5 output beats of a row
    for (int i = 1; i <= 4; i++) send_a(i, i == 4);
    got5 = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #2;
      if (log_d.size() >= 5) begin
        got5 = 1'b1;
        break;
      end
    end
    chk("five_beats_seen", {31'd0, got5}, 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst_valid", {31'd0, a_out_valid}, 32'd0);
    chk("midrst_last", {31'd0, a_out_last}, 32'd0);
    chk("midrst_data", a_out_data, 32'd0);
    chk("midrst_ready", {31'd0, a_in_ready}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    #1 chk("midrst_ready_after", {31'd0, a_in_ready}, 32'd1);
    log_d.delete();
    log_l.delete();
    for (int i = 1; i <= 4; i++) send_a(i * 10, i == 4);
    wait_idle();
    exp_lit = '{10,10,20,20,30,30,40,40,10,10,20,20,30,30,40,40};
    $display("scenario reset_recover beats=%0d", log_d.size());
    chk_log("s5", 15);

    // SCALE=1, IN_WIDTH=3 store-and-forward
    for (int i = 0; i < 3; i++) begin
      b_in_data = 5 + i; b_in_valid = 1'b1; b_in_last = (i == 2);
      @(negedge clk);
      chk("b_in_ready", {31'd0, b_in_ready}, 32'd1);
      @(posedge clk);
      #1;
    end
    b_in_valid = 1'b0; b_in_last = 1'b0;
    @(negedge clk);
    chk("b_valid_n1", {31'd0, b_out_valid}, 32'd1);
    chk("b_data_0", b_out_data, 32'd5);
    chk("b_last_0", {31'd0, b_out_last}, 32'd0);
    @(negedge clk);
    chk("b_data_1", b_out_data, 32'd6);
    chk("b_last_1", {31'd0, b_out_last}, 32'd0);
    @(negedge clk);
    chk("b_data_2", b_out_data, 32'd7);
    chk("b_last_2", {31'd0, b_out_last}, 32'd1);
    @(negedge clk);
    chk("b_valid_end", {31'd0, b_out_valid}, 32'd0);
    chk("b_ready_end", {31'd0, b_in_ready}, 32'd1);
    $display("scenario scale1 done");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/upsampling_unit.md
# upsampling_unit

Nearest-neighbour upsampler for the CNN datapath: the inverse of the max-pooling stage. Accepts a row-major stream of feature-map pixels, buffers one input row, and emits each row `SCALE` times with each pixel repeated `SCALE` times. It sits between a pooled feature map and a decoder or skip-connection stage that needs the original spatial resolution. Valid/ready handshakes are used on both sides, and `last` flags mark frame boundaries.

## Interface
- `DATA_WIDTH`, 32, pixel width in bits
- `SCALE`, 2, upsampling factor per axis (≥1)
- `IN_WIDTH`, 8, pixels per full input row (≥1)

- `clk`  in  1  clock
- `reset`  in  1  reset, asynchronous, active-high
- `input_data`  in  DATA_WIDTH  input pixel
- `input_valid`  in  1  input beat offered
- `input_ready`  out  1  unit can accept an input beat
- `last_input`  in  1  marks the final pixel of the frame; qualified by a transfer
- `output_data`  out  DATA_WIDTH  upsampled pixel
- `output_valid`  out  1  output beat offered
- `output_ready`  in  1  downstream accepts the output beat
- `last_output`  out  1  marks the final output pixel of the frame; qualified by `output_valid`

## Operation
- Input transfer: `input_valid && input_ready` at a rising edge. Output transfer: `output_valid && output_ready` at a rising edge.
- Storage: row buffer of `IN_WIDTH` x `DATA_WIDTH`.
- Registers:
  - `in_col` counter, 0..IN_WIDTH-1
  - `row_len`
  - `src_col`
  - `rep_x` counter, 0..SCALE-1
  - `rep_y` counter, 0..SCALE-1
  - `frame_last` flag
- Counters are sized by `$clog2` of their range, minimum 1 bit.
- States:
  - LOAD (reset state): `input_ready`=1, `output_valid`=0. Each input transfer writes `buf[in_col]` and increments `in_col`.
    - LOAD exits to EMIT on a transfer with `in_col==IN_WIDTH-1`, or on a transfer with `last_input`=1.
    - On exit: `row_len` = `in_col`+1, `frame_last` = `last_input`, `in_col` cleared, `src_col`/`rep_x`/`rep_y` cleared.
  - EMIT: `input_ready`=0, `output_valid`=1, `output_data`=`buf[src_col]`. Each output transfer does the following:
    - Advance `rep_x`. At `SCALE-1`, wrap `rep_x` and advance `src_col`.
    - At `src_col==row_len-1` with `rep_x==SCALE-1`, wrap `src_col` and advance `rep_y`.
    - At `rep_y==SCALE-1` as well, this is the final beat of the row: go to LOAD and clear `frame_last`.
- `last_output` = EMIT && `frame_last` && final beat of the row (`rep_y==SCALE-1`, `src_col==row_len-1`, `rep_x==SCALE-1`).
- Short row: `last_input` before `IN_WIDTH` beats truncates the row. Output rows are then `row_len*SCALE` wide; stale buffer entries are never emitted.
- Per input row, exactly `SCALE*SCALE*row_len` output beats are emitted.
- `output_data` and `output_valid` depend only on registers; there is no combinational path from `output_ready`.
- `SCALE`=1 degenerates to a store-and-forward row buffer.

## Timing
- Reset values: `output_valid`=0, `last_output`=0, `output_data`=0, `input_ready`=0 while `reset` is high.
- `input_ready`=1 in the first cycle after `reset` deasserts.
- Latency: the last input beat of a row is accepted at edge N. `output_valid` rises in the cycle after edge N, and the first output beat can transfer at edge N+1.
- Throughput: 1 beat/cycle in each state. A full row costs `IN_WIDTH + SCALE²·IN_WIDTH` cycles with `output_ready` held high.
- Backpressure: while `output_ready`=0 in EMIT, `output_data`, `output_valid`, `last_output` and all counters hold.
- Input is never accepted in EMIT, and output is never offered in LOAD. Input and output transfers therefore never occur in the same cycle.
- After the final beat of a frame, the unit returns to LOAD with all counters at 0 and is ready for the next frame with no gap cycle.
- Reset mid-operation:
  - Asynchronous return to LOAD, with counters and flags cleared.
  - Any partial row or in-progress emission is discarded.
  - Buffer contents are not cleared; they are unobservable until rewritten.

## Test plan
- IN_WIDTH=4, SCALE=2, `output_ready`=1: input row 1,2,3,4 with `last_input` on 4. Required output: 1,1,2,2,3,3,4,4,1,1,2,2,3,3,4,4, with `last_output` only on the 16th beat. `input_ready`=0 for those 16 cycles.
- Two rows, 1..4 then 5..8, `last_input` on 8. Required: 16 beats of row 1 with no `last_output`, then 16 beats of row 2 with `last_output` on the final 8. `input_ready` reasserts the cycle after beat 16.
- Short row: 9,7 with `last_input` on 7 (IN_WIDTH=4). Required output: 9,9,7,7,9,9,7,7, with `last_output` on beat 8. No stale values appear.
- Backpressure: row 1..4, `output_ready` toggling 1,0,0,1,… Required: `output_data`, `output_valid` and `last_output` hold during 0 cycles, and the transferred sequence is identical to the first scenario.
- Reset asserted during EMIT after 5 output beats. Required: `output_valid`=0 immediately and `input_ready`=1 after release. A new row 10,20,30,40 then yields 10,10,20,20,…, with no residue from the aborted row.
- SCALE=1, IN_WIDTH=3: input 5,6,7 with last. Required output: 5,6,7, with `last_output` on 7 and first output at edge N+1.
